// File: rtl/r_alu_sequencer_pkg.sv
// r_alu_pkg: shared definitions for the R-format ALU control sequencer.
//   - LEGv8 R-format opcode values (instr[31:21])
//   - ALU op codes (upper three bits of Fsel)
//   - Psel / Dsel encodings used in the control word
//   - sequencer state enum
//   - cw_width(): control-word width as a function of the register-address width
package r_alu_pkg;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_ORR    = 3'b001;
    localparam logic [2:0] OP_ADDSUB = 3'b010;
    localparam logic [2:0] OP_EOR    = 3'b011;
    localparam logic [2:0] OP_LSL    = 3'b100;
    localparam logic [2:0] OP_LSR    = 3'b101;
    localparam logic [2:0] OP_MUL    = 3'b110;

    localparam logic [1:0] PSEL_HOLD = 2'b00;  // PC held (intermediate MUL beat)
    localparam logic [1:0] PSEL_INC  = 2'b01;  // PC advances
    localparam logic [1:0] DSEL_ALU  = 2'b01;  // register write data from ALU

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MULTI = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    // {Psel[1:0], DA, SA, SB, Fsel[4:0], regW, ramW, Dsel[1:0], Bsel, PCsel, SL}
    function automatic int cw_width(input int reg_aw);
        return 14 + 3 * reg_aw;
    endfunction

endpackage

// File: rtl/r_alu_sequencer_if.sv
// r_alu_sequencer_if: instruction-in / control-word-out bundle.
//   instr_valid/instr_ready : fetch -> sequencer handshake
//   instruction             : R-format word, sampled on the accepting edge
//   cw_valid/control_word   : one registered control beat per cycle while busy
//   busy, illegal           : status
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid && instr_ready are both high; the source must hold instruction
// stable while instr_valid is high and ready is low. cw_valid has no back
// pressure: each beat is presented for exactly one cycle.
interface r_alu_sequencer_if #(
    parameter int REG_AW = 5
);
    localparam int CW_W = r_alu_pkg::cw_width(REG_AW);

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instruction;
    logic            cw_valid;
    logic [CW_W-1:0] control_word;
    logic            busy;
    logic            illegal;

    modport master (
        output instr_valid, instruction,
        input  instr_ready, cw_valid, control_word, busy, illegal
    );

    modport slave (
        input  instr_valid, instruction,
        output instr_ready, cw_valid, control_word, busy, illegal
    );
endinterface

// File: rtl/r_alu_sequencer_field_decode.sv
// r_alu_field_decode: combinational R-format opcode classifier.
//   i_opcode  : instr[31:21]
//   o_op      : ALU op code (Fsel[4:2])
//   o_inv_a   : invert-A for ADD/SUB family (instr[30]), else 0
//   o_bsel    : 1 for shifts (B operand is the shamt field)
//   o_is_mul  : multi-beat op
//   o_legal   : opcode is one of the supported R-format ops
module r_alu_field_decode
    import r_alu_pkg::*;
(
    input  logic [10:0] i_opcode,
    output logic [2:0]  o_op,
    output logic        o_inv_a,
    output logic        o_bsel,
    output logic        o_is_mul,
    output logic        o_legal
);
    always_comb begin
        o_op     = OP_AND;
        o_inv_a  = 1'b0;
        o_bsel   = 1'b0;
        o_is_mul = 1'b0;
        o_legal  = 1'b1;
        case (i_opcode)
            OPC_ADD, OPC_ADDS, OPC_SUB, OPC_SUBS: begin
                o_op    = OP_ADDSUB;
                o_inv_a = i_opcode[9];  // instr[30] distinguishes SUB from ADD
            end
            OPC_AND: o_op = OP_AND;
            OPC_ORR: o_op = OP_ORR;
            OPC_EOR: o_op = OP_EOR;
            OPC_LSL: begin
                o_op   = OP_LSL;
                o_bsel = 1'b1;
            end
            OPC_LSR: begin
                o_op   = OP_LSR;
                o_bsel = 1'b1;
            end
            OPC_MUL: begin
                o_op     = OP_MUL;
                o_is_mul = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/r_alu_sequencer.sv
// r_alu_sequencer: registered R-format control sequencer.
//   i_clock, i_reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)      : instruction handshake in, control-word beats out
//   o_state          : current FSM state (debug)
// Parameters: REG_AW register-address width, MUL_CYCLES beats per MUL (>=1).
// Build option: R_ALU_SEQ_ILLEGAL_TRAP_EN makes an undecoded opcode trap
// (sticky illegal, no more instructions until reset); otherwise it issues a
// single NOP beat and the sequencer keeps running.
module r_alu_sequencer
    import r_alu_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic  i_clock,
    input  logic  i_reset,
    r_alu_sequencer_if.slave bus,
    output state_t o_state
);
    localparam int CW_W  = cw_width(REG_AW);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    state_t            r_state;
    logic [31:0]       r_instr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cw_valid;
    logic [CW_W-1:0]   r_cw;

    logic [31:0] w_dec_instr;
    logic [2:0]  w_op;
    logic        w_inv_a;
    logic        w_bsel;
    logic        w_is_mul;
    logic        w_legal;
    logic        w_first_last;

    // The first beat is built from the live instruction on the accepting
    // edge; every later beat uses the latched copy.
    assign w_dec_instr = (r_state == S_FETCH) ? bus.instruction : r_instr;

    r_alu_field_decode u_decode (
        .i_opcode (w_dec_instr[31:21]),
        .o_op     (w_op),
        .o_inv_a  (w_inv_a),
        .o_bsel   (w_bsel),
        .o_is_mul (w_is_mul),
        .o_legal  (w_legal)
    );

    assign w_first_last = !w_is_mul || (MUL_CYCLES == 1);

    // One control beat. 'last' selects the PC-advancing, write-back beat.
    // Undecoded opcodes produce a NOP: Fsel=0, SL=0, regW=0.
    function automatic logic [CW_W-1:0] make_cw(input logic [31:0] ins,
                                                 input logic last);
        logic [1:0]        psel;
        logic [REG_AW-1:0] da;
        logic [4:0]        fsel;
        logic              regw;
        logic              sl;
        psel = last ? PSEL_INC : PSEL_HOLD;
        da   = ins[REG_AW-1:0];
        fsel = w_legal ? {w_op, w_inv_a, 1'b0} : 5'b0;
        regw = last && w_legal && !(&da);  // XZR destination never written
        sl   = w_legal && !w_is_mul && ins[29];
        return {psel, da, ins[16 +: REG_AW], ins[5 +: REG_AW], fsel,
                regw, 1'b0, DSEL_ALU, w_bsel && w_legal, 1'b0, sl};
    endfunction

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_instr    <= '0;
            r_cnt      <= '0;
            r_cw_valid <= 1'b0;
            r_cw       <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_instr <= bus.instruction;
`ifdef R_ALU_SEQ_ILLEGAL_TRAP_EN
                        if (!w_legal) begin
                            r_state <= S_TRAP;
                        end else begin
                            r_state    <= S_EXEC;
                            r_cw_valid <= 1'b1;
                            r_cw       <= make_cw(bus.instruction, w_first_last);
                        end
`else
                        r_state    <= S_EXEC;
                        r_cw_valid <= 1'b1;
                        r_cw       <= make_cw(bus.instruction, w_first_last);
`endif
                    end
                end
                S_EXEC: begin
                    if (w_is_mul && (MUL_CYCLES > 1)) begin
                        // Counter holds the number of beats still to present,
                        // including the one issued on this edge.
                        r_state <= S_MULTI;
                        r_cnt   <= CNT_W'(MUL_CYCLES - 1);
                        r_cw    <= make_cw(r_instr, (MUL_CYCLES - 1) == 1);
                    end else begin
                        r_state    <= S_FETCH;
                        r_cw_valid <= 1'b0;
                        r_cw       <= '0;
                    end
                end
                S_MULTI: begin
                    if (r_cnt > CNT_W'(1)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        r_cw  <= make_cw(r_instr, r_cnt == CNT_W'(2));
                    end else begin
                        r_state    <= S_FETCH;
                        r_cnt      <= '0;
                        r_cw_valid <= 1'b0;
                        r_cw       <= '0;
                    end
                end
                default: begin
                    // S_TRAP: parked until reset.
                    r_cw_valid <= 1'b0;
                    r_cw       <= '0;
                end
            endcase
        end
    end

    assign bus.instr_ready  = (r_state == S_FETCH);
    assign bus.busy         = (r_state != S_FETCH);
    assign bus.cw_valid     = r_cw_valid;
    assign bus.control_word = r_cw;
    assign o_state          = r_state;

`ifdef R_ALU_SEQ_ILLEGAL_TRAP_EN
    assign bus.illegal = (r_state == S_TRAP);  // only reset leaves S_TRAP
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
